pipe_regs: RTL

PIPE_REGS -- requirements
Module: pipe_regs

---
 rtl/pipe_regs_if.sv | 47 ++++
 rtl/pipe_regs.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_regs_if.sv
// Pipeline register bundle: fetch/RF/ALU/memory inputs, stage registers,
// forwarded operands and the register-file write port.
interface pipe_regs_if;
   logic [31:0] if_ir;
   logic [31:0] rf_r1;
   logic [31:0] rf_r2;
   logic [31:0] alu_res;
   logic [31:0] mem_rdata;
   logic        stall;
   logic        sig1_ex_mem_rs;
   logic        sig1_mem_wb_rs;
   logic        sig1_mem_wb_mm;
   logic        sig2_ex_mem_rs;
   logic        sig2_mem_wb_rs;
   logic        sig2_mem_wb_mm;
   logic [31:0] ir1;
   logic [31:0] ir2;
   logic [31:0] ir3;
   logic [31:0] ir4;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [31:0] ex_mem_rs;
   logic [31:0] mem_wb_rs;
   logic [31:0] mem_wb_mm;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        if_hold;

   modport master (
      output if_ir, rf_r1, rf_r2, alu_res, mem_rdata, stall,
      output sig1_ex_mem_rs, sig1_mem_wb_rs, sig1_mem_wb_mm,
      output sig2_ex_mem_rs, sig2_mem_wb_rs, sig2_mem_wb_mm,
      input  ir1, ir2, ir3, ir4, ex_a, ex_b,
      input  ex_mem_rs, mem_wb_rs, mem_wb_mm,
      input  wb_en, wb_addr, wb_data, if_hold
   );

   modport slave (
      input  if_ir, rf_r1, rf_r2, alu_res, mem_rdata, stall,
      input  sig1_ex_mem_rs, sig1_mem_wb_rs, sig1_mem_wb_mm,
      input  sig2_ex_mem_rs, sig2_mem_wb_rs, sig2_mem_wb_mm,
      output ir1, ir2, ir3, ir4, ex_a, ex_b,
      output ex_mem_rs, mem_wb_rs, mem_wb_mm,
      output wb_en, wb_addr, wb_data, if_hold
   );
endinterface

// File: rtl/pipe_regs.sv
// Five-stage pipeline registers with forwarding, ID bypass and stall bubbles.
// Optional stall counter output enabled by defining PIPE_STALL_CNT_EN.
module pipe_regs (
   input  logic        clk,
   input  logic        rst,
`ifdef PIPE_STALL_CNT_EN
   output logic [15:0] stall_cnt,
`endif
   pipe_regs_if.slave  bus
);

   localparam logic [5:0] OP_ALU = 6'b000000;
   localparam logic [5:0] OP_CMP = 6'b111110;
   localparam logic [5:0] OP_LD  = 6'b100011;

   logic [31:0] ir1_q;
   logic [31:0] ir2_q;
   logic [31:0] ir3_q;
   logic [31:0] ir4_q;
   logic [31:0] id_a_q;
   logic [31:0] id_b_q;
   logic [31:0] ex_mem_rs_q;
   logic [31:0] mem_wb_rs_q;
   logic [31:0] mem_wb_mm_q;

   logic [5:0]  wb_op;
   logic        wb_rd_cls;
   logic        wb_ld_cls;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [31:0] ex_a;
   logic [31:0] ex_b;

   assign wb_op     = ir4_q[31:26];
   assign wb_rd_cls = (wb_op == OP_ALU) || (wb_op == OP_CMP);
   assign wb_ld_cls = (wb_op == OP_LD);

   always_comb begin
      wb_addr = 5'd0;
      wb_data = 32'd0;
      wb_en   = 1'b0;
      unique case (1'b1)
         wb_rd_cls: begin
            wb_addr = ir4_q[15:11];
            wb_data = mem_wb_rs_q;
            wb_en   = (ir4_q[15:11] != 5'd0);
         end
         wb_ld_cls: begin
            wb_addr = ir4_q[20:16];
            wb_data = mem_wb_mm_q;
            wb_en   = (ir4_q[20:16] != 5'd0);
         end
         default: ;
      endcase
   end

   // Same-cycle write-back is visible to the instruction being decoded
   assign op1 = (wb_en && wb_addr == ir1_q[25:21]) ? wb_data : bus.rf_r1;
   assign op2 = (wb_en && wb_addr == ir1_q[20:16]) ? wb_data : bus.rf_r2;

   always_comb begin
      ex_a = id_a_q;
      priority case (1'b1)
         bus.sig1_ex_mem_rs: ex_a = ex_mem_rs_q;
         bus.sig1_mem_wb_rs: ex_a = mem_wb_rs_q;
         bus.sig1_mem_wb_mm: ex_a = mem_wb_mm_q;
         default:            ex_a = id_a_q;
      endcase
   end

   always_comb begin
      ex_b = id_b_q;
      priority case (1'b1)
         bus.sig2_ex_mem_rs: ex_b = ex_mem_rs_q;
         bus.sig2_mem_wb_rs: ex_b = mem_wb_rs_q;
         bus.sig2_mem_wb_mm: ex_b = mem_wb_mm_q;
         default:            ex_b = id_b_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir1_q  <= 32'd0;
         ir2_q  <= 32'd0;
         id_a_q <= 32'd0;
         id_b_q <= 32'd0;
      end else if (bus.stall) begin
         ir2_q  <= 32'd0;
         id_a_q <= 32'd0;
         id_b_q <= 32'd0;
      end else begin
         ir1_q  <= bus.if_ir;
         ir2_q  <= ir1_q;
         id_a_q <= op1;
         id_b_q <= op2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir3_q       <= 32'd0;
         ir4_q       <= 32'd0;
         ex_mem_rs_q <= 32'd0;
         mem_wb_rs_q <= 32'd0;
         mem_wb_mm_q <= 32'd0;
      end else begin
         ir3_q       <= ir2_q;
         ir4_q       <= ir3_q;
         ex_mem_rs_q <= bus.alu_res;
         mem_wb_rs_q <= ex_mem_rs_q;
         mem_wb_mm_q <= bus.mem_rdata;
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 16'd0;
      end else if (bus.stall && cnt_q != 16'hFFFF) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign stall_cnt = cnt_q;
`endif

   assign bus.ir1       = ir1_q;
   assign bus.ir2       = ir2_q;
   assign bus.ir3       = ir3_q;
   assign bus.ir4       = ir4_q;
   assign bus.ex_a      = ex_a;
   assign bus.ex_b      = ex_b;
   assign bus.ex_mem_rs = ex_mem_rs_q;
   assign bus.mem_wb_rs = mem_wb_rs_q;
   assign bus.mem_wb_mm = mem_wb_mm_q;
   assign bus.wb_en     = wb_en;
   assign bus.wb_addr   = wb_addr;
   assign bus.wb_data   = wb_data;
   assign bus.if_hold   = bus.stall;

endmodule
